// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Two-master arbiter in front of a single-port data memory. Grants at most one
// request per cycle (round-robin when both ask), supports bus locking with an
// idle timeout, range-checks addresses and returns read data one cycle after
// the grant.
//
// Parameters
//   MEM_WORDS     data memory depth in 32-bit words
//   LOCK_TIMEOUT  idle cycles a locked master may sit without requesting
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   mN_req/lock/be/addr/wdata   master N request side (N = 0,1)
//   mN_gnt                 request accepted this cycle (combinational pulse)
//   mN_rvalid/rdata        read response, one cycle after the grant
//   mN_err                 out-of-range access or lock timeout
//   mem_addr/wdata/be      memory request, valid in the grant cycle
//   mem_rdata              combinational memory read data at mem_addr
// -----------------------------------------------------------------------------
module dm_arbiter #(
  parameter int MEM_WORDS    = 3072,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam int                IDLE_W      = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [31:0]       MEM_WORDS_W = 32'(MEM_WORDS);
  localparam logic [IDLE_W-1:0] TIMEOUT_W   = IDLE_W'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t            state_reg, state_next;
  logic              ptr_reg, ptr_next;     // preferred master on a tie
  logic [IDLE_W-1:0] idle_reg, idle_next;

  logic [1:0]  req_vec;
  logic [1:0]  lock_vec;
  logic [3:0]  be_arr    [2];
  logic [31:0] addr_arr  [2];
  logic [31:0] wdata_arr [2];

  logic [1:0]  gnt_vec;
  logic [1:0]  timeout_vec;

  logic        sel;
  logic        any_gnt;
  logic [31:0] addr_sel;
  logic [31:0] wdata_sel;
  logic [3:0]  be_sel;
  logic        in_range;
  logic        is_read;

  logic [1:0]  rvalid_out;
  logic [1:0]  err_out;
  logic [31:0] rdata_out [2];

  assign req_vec      = {m1_req, m0_req};
  assign lock_vec     = {m1_lock, m0_lock};
  assign be_arr[0]    = m0_be;
  assign be_arr[1]    = m1_be;
  assign addr_arr[0]  = m0_addr;
  assign addr_arr[1]  = m1_addr;
  assign wdata_arr[0] = m0_wdata;
  assign wdata_arr[1] = m1_wdata;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ARB;
      ptr_reg   <= 1'b0;
      idle_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      idle_reg  <= idle_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and grant logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    idle_next   = idle_reg;
    gnt_vec     = 2'b00;
    timeout_vec = 2'b00;

    case (state_reg)
      ARB: begin
        if (req_vec == 2'b11) begin
          gnt_vec[ptr_reg] = 1'b1;
        end else begin
          gnt_vec = req_vec;
        end
        if (gnt_vec != 2'b00) begin
          // Winner loses priority on the next tie.
          ptr_next  = gnt_vec[0];
          idle_next = '0;
          if (gnt_vec[0] && lock_vec[0]) begin
            state_next = LOCK0;
          end else if (gnt_vec[1] && lock_vec[1]) begin
            state_next = LOCK1;
          end
        end
      end

      LOCK0: begin
        // An expired lock is released without serving anyone this cycle.
        if (idle_reg == TIMEOUT_W) begin
          timeout_vec[0] = 1'b1;
          state_next     = ARB;
          idle_next      = '0;
        end else if (req_vec[0]) begin
          gnt_vec[0] = 1'b1;
          idle_next  = '0;
          if (!lock_vec[0]) begin
            state_next = ARB;
          end
        end else begin
          idle_next = idle_reg + IDLE_W'(1);
        end
      end

      LOCK1: begin
        if (idle_reg == TIMEOUT_W) begin
          timeout_vec[1] = 1'b1;
          state_next     = ARB;
          idle_next      = '0;
        end else if (req_vec[1]) begin
          gnt_vec[1] = 1'b1;
          idle_next  = '0;
          if (!lock_vec[1]) begin
            state_next = ARB;
          end
        end else begin
          idle_next = idle_reg + IDLE_W'(1);
        end
      end

      default: begin
        state_next = ARB;
        idle_next  = '0;
      end
    endcase

    // No grants or timeout pulses while reset is held; the registers are
    // cleared at the edge anyway, this keeps the outputs quiet in that cycle.
    if (reset) begin
      gnt_vec     = 2'b00;
      timeout_vec = 2'b00;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory request path (steered by the granted master)
  // ---------------------------------------------------------------------------
  assign sel       = gnt_vec[1];
  assign any_gnt   = |gnt_vec;
  assign addr_sel  = sel ? addr_arr[1]  : addr_arr[0];
  assign wdata_sel = sel ? wdata_arr[1] : wdata_arr[0];
  assign be_sel    = sel ? be_arr[1]    : be_arr[0];
  assign in_range  = (addr_sel >> 2) < MEM_WORDS_W;
  assign is_read   = (be_sel == 4'b0000);

  assign mem_addr  = addr_sel & 32'hFFFF_FFFC;
  assign mem_wdata = wdata_sel;
  assign mem_be    = (any_gnt && in_range) ? be_sel : 4'b0000;

  // ---------------------------------------------------------------------------
  // Per-master response registers
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      logic        rvalid_reg;
      logic        err_reg;
      logic [31:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          rvalid_reg <= 1'b0;
          err_reg    <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= gnt_vec[gi] & is_read;
          err_reg    <= gnt_vec[gi] & ~in_range;
          // Out-of-range reads still respond, with zero data.
          rdata_reg  <= (gnt_vec[gi] && is_read && in_range) ? mem_rdata : 32'h0;
        end
      end

      // A response due in a reset cycle is dropped.
      assign rvalid_out[gi] = rvalid_reg & ~reset;
      assign err_out[gi]    = (err_reg | timeout_vec[gi]) & ~reset;
      assign rdata_out[gi]  = reset ? 32'h0 : rdata_reg;
    end
  endgenerate

  assign m0_gnt    = gnt_vec[0];
  assign m1_gnt    = gnt_vec[1];
  assign m0_rvalid = rvalid_out[0];
  assign m1_rvalid = rvalid_out[1];
  assign m0_err    = err_out[0];
  assign m1_err    = err_out[1];
  assign m0_rdata  = rdata_out[0];
  assign m1_rdata  = rdata_out[1];

endmodule
